// File: rtl/ysyx_22040750_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22040750_mem_arbiter
//
// Purpose:
//   Serialises the instruction-fetch requester (IF) and the load/store
//   requester (LS) onto a single memory port, one outstanding transaction at
//   a time. LS has priority, but after MAX_LS_STREAK consecutive LS grants
//   made while IF was waiting, IF is forced through. A flush cancels the
//   delivery of an in-flight fetch response without aborting the memory
//   transaction itself.
//
// Ports:
//   I_sys_clk, I_rst          clock (rising edge), async active-high reset
//   I_if_req/I_if_addr        fetch request, held until O_if_ready
//   O_if_ready                fetch accepted (IDLE cycle, combinational)
//   O_if_rvalid/O_if_rdata    fetch response pulse / data
//   I_ls_req/wen/addr/wdata/wmask  load/store request, held until O_ls_ready
//   O_ls_ready                load/store accepted (IDLE cycle, combinational)
//   O_ls_rvalid/O_ls_rdata    load data / store completion pulse
//   I_flush                   squash current or pending fetch
//   O_mem_req/wen/addr/wdata/wmask  memory request (fields registered)
//   I_mem_ready               memory accepts the request this cycle
//   I_mem_rvalid/I_mem_rdata  memory response
//   O_busy                    arbiter not idle
// ----------------------------------------------------------------------------
module ysyx_22040750_mem_arbiter #(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_if_req,
  input  logic [31:0] I_if_addr,
  output logic        O_if_ready,
  output logic        O_if_rvalid,
  output logic [31:0] O_if_rdata,
  input  logic        I_ls_req,
  input  logic        I_ls_wen,
  input  logic [31:0] I_ls_addr,
  input  logic [31:0] I_ls_wdata,
  input  logic [3:0]  I_ls_wmask,
  output logic        O_ls_ready,
  output logic        O_ls_rvalid,
  output logic [31:0] O_ls_rdata,
  input  logic        I_flush,
  output logic        O_mem_req,
  output logic        O_mem_wen,
  output logic [31:0] O_mem_addr,
  output logic [31:0] O_mem_wdata,
  output logic [3:0]  O_mem_wmask,
  input  logic        I_mem_ready,
  input  logic        I_mem_rvalid,
  input  logic [31:0] I_mem_rdata,
  output logic        O_busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ_IF  = 3'd1,
    ST_REQ_LS  = 3'd2,
    ST_WAIT_IF = 3'd3,
    ST_WAIT_LS = 3'd4
  } state_t;

  localparam logic [3:0] LP_MAX_STREAK = MAX_LS_STREAK[3:0];

  state_t      r_state;
  logic [3:0]  r_streak;
  logic        r_drop;
  logic        r_mem_wen;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wmask;

  logic w_idle;
  logic w_ls_grant;
  logic w_if_grant;

  assign w_idle = (r_state == ST_IDLE);

  // LS is held back only when the streak limit is reached AND IF could
  // actually be granted instead. If IF is flushed or not requesting at all,
  // holding LS back would just waste the cycle (or deadlock), so LS goes.
  assign w_ls_grant = w_idle & I_ls_req &
                      ((r_streak < LP_MAX_STREAK) | I_flush | ~I_if_req);
  assign w_if_grant = w_idle & I_if_req & ~I_flush & ~w_ls_grant;

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state     <= ST_IDLE;
      r_streak    <= 4'd0;
      r_drop      <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wmask <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_drop <= 1'b0;
          if (w_ls_grant) begin
            r_mem_wen   <= I_ls_wen;
            r_mem_addr  <= I_ls_addr;
            r_mem_wdata <= I_ls_wdata;
            r_mem_wmask <= I_ls_wmask;
            // Only grants that made IF wait count toward starvation.
            if (I_if_req && (r_streak != 4'hF)) begin
              r_streak <= r_streak + 4'd1;
            end
            r_state <= ST_REQ_LS;
          end else if (w_if_grant) begin
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= I_if_addr;
            r_mem_wdata <= 32'd0;
            r_mem_wmask <= 4'd0;
            r_streak    <= 4'd0;
            r_state     <= ST_REQ_IF;
          end
        end
        ST_REQ_IF: begin
          if (I_flush) begin
            r_drop <= 1'b1;
          end
          if (I_mem_ready) begin
            r_state <= ST_WAIT_IF;
          end
        end
        ST_WAIT_IF: begin
          if (I_mem_rvalid) begin
            r_drop  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (I_flush) begin
            r_drop <= 1'b1;
          end
        end
        ST_REQ_LS: begin
          if (I_mem_ready) begin
            r_state <= ST_WAIT_LS;
          end
        end
        ST_WAIT_LS: begin
          if (I_mem_rvalid) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign O_if_ready  = w_if_grant;
  assign O_ls_ready  = w_ls_grant;

  // A flush arriving together with the response must also squash it.
  assign O_if_rvalid = (r_state == ST_WAIT_IF) & I_mem_rvalid & ~r_drop & ~I_flush;
  assign O_ls_rvalid = (r_state == ST_WAIT_LS) & I_mem_rvalid;
  assign O_if_rdata  = I_mem_rdata;
  assign O_ls_rdata  = I_mem_rdata;

  assign O_mem_req   = (r_state == ST_REQ_IF) | (r_state == ST_REQ_LS);
  assign O_mem_wen   = r_mem_wen;
  assign O_mem_addr  = r_mem_addr;
  assign O_mem_wdata = r_mem_wdata;
  assign O_mem_wmask = r_mem_wmask;
  assign O_busy      = ~w_idle;

endmodule

// File: tb/tb_ysyx_22040750_mem_arbiter.sv
module tb_ysyx_22040750_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_wen;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wmask;
  logic        ls_ready;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        flush;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_checks;
  int n_fails;

  ysyx_22040750_mem_arbiter #(.MAX_LS_STREAK(4)) dut (
    .I_sys_clk   (clk),
    .I_rst       (rst),
    .I_if_req    (if_req),
    .I_if_addr   (if_addr),
    .O_if_ready  (if_ready),
    .O_if_rvalid (if_rvalid),
    .O_if_rdata  (if_rdata),
    .I_ls_req    (ls_req),
    .I_ls_wen    (ls_wen),
    .I_ls_addr   (ls_addr),
    .I_ls_wdata  (ls_wdata),
    .I_ls_wmask  (ls_wmask),
    .O_ls_ready  (ls_ready),
    .O_ls_rvalid (ls_rvalid),
    .O_ls_rdata  (ls_rdata),
    .I_flush     (flush),
    .O_mem_req   (mem_req),
    .O_mem_wen   (mem_wen),
    .O_mem_addr  (mem_addr),
    .O_mem_wdata (mem_wdata),
    .O_mem_wmask (mem_wmask),
    .I_mem_ready (mem_ready),
    .I_mem_rvalid(mem_rvalid),
    .I_mem_rdata (mem_rdata),
    .O_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks are taken 2 units
  // later, well away from both clock edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; ls_req = 0; ls_wen = 0; ls_addr = 0;
    ls_wdata = 0; ls_wmask = 0; flush = 0; mem_ready = 0; mem_rvalid = 0;
    mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL reset_mem_req got %0b want 0", mem_req); end
    n_checks++; if ({mem_wen, mem_addr, mem_wdata, mem_wmask} !== 69'd0) begin n_fails++; $display("FAIL reset_mem_fields got %h want 0", {mem_wen, mem_addr, mem_wdata, mem_wmask}); end
    n_checks++; if ({if_ready, ls_ready, if_rvalid, ls_rvalid} !== 4'b0) begin n_fails++; $display("FAIL reset_handshake got %b want 0000", {if_ready, ls_ready, if_rvalid, ls_rvalid}); end
    rst = 0;
    $display("test_reset done");
  endtask

  task automatic test_if_basic();
    do_reset();
    if_req = 1; if_addr = 32'h8000_0000; mem_ready = 1;
    #2;
    n_checks++; if (if_ready !== 1'b1 || ls_ready !== 1'b0) begin n_fails++; $display("FAIL if_basic_ready got if=%0b ls=%0b want 1/0", if_ready, ls_ready); end
    tick();
    if_req = 0;
    #2;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin n_fails++; $display("FAIL if_basic_req got req=%0b addr=%h wen=%0b want 1/80000000/0", mem_req, mem_addr, mem_wen); end
    n_checks++; if (mem_wmask !== 4'h0 || mem_wdata !== 32'h0) begin n_fails++; $display("FAIL if_basic_fields got wmask=%h wdata=%h want 0/0", mem_wmask, mem_wdata); end
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #2;
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0013) begin n_fails++; $display("FAIL if_basic_rvalid got v=%0b d=%h want 1/00000013", if_rvalid, if_rdata); end
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("FAIL if_basic_req_wait got %0b want 0", mem_req); end
    tick();
    mem_rvalid = 0; mem_ready = 0;
    #2;
    n_checks++; if (busy !== 1'b0 || if_rvalid !== 1'b0) begin n_fails++; $display("FAIL if_basic_idle got busy=%0b rvalid=%0b want 0/0", busy, if_rvalid); end
    $display("test_if_basic done");
  endtask

  task automatic test_priority();
    logic [9:0] order;
    logic       exp_ls;
    // bit k = 1 means LS expected for transaction k (LSB first)
    order = 10'b01111_01111;
    do_reset();
    if_req = 1; if_addr = 32'h8000_0100;
    ls_req = 1; ls_wen = 1; ls_addr = 32'h8000_2000; ls_wdata = 32'hA5A5_0000; ls_wmask = 4'h3;
    mem_ready = 1;
    for (int k = 0; k < 10; k++) begin
      exp_ls = order[k];
      #2;
      n_checks++; if (ls_ready !== exp_ls || if_ready !== ~exp_ls) begin n_fails++; $display("FAIL prio_grant[%0d] got ls=%0b if=%0b want ls=%0b", k, ls_ready, if_ready, exp_ls); end
      tick();
      #2;
      n_checks++; if (mem_req !== 1'b1 || mem_wen !== exp_ls || mem_addr !== (exp_ls ? 32'h8000_2000 : 32'h8000_0100)) begin n_fails++; $display("FAIL prio_fields[%0d] got req=%0b wen=%0b addr=%h want ls=%0b", k, mem_req, mem_wen, mem_addr, exp_ls); end
      tick();
      mem_rvalid = 1; mem_rdata = 32'h100 + k;
      #2;
      n_checks++; if (ls_rvalid !== exp_ls || if_rvalid !== ~exp_ls) begin n_fails++; $display("FAIL prio_rvalid[%0d] got ls=%0b if=%0b want ls=%0b", k, ls_rvalid, if_rvalid, exp_ls); end
      tick();
      mem_rvalid = 0;
      $display("priority txn %0d granted %s", k, exp_ls ? "LS" : "IF");
    end
    clear_inputs();
    $display("test_priority done");
  endtask

  task automatic test_flush();
    do_reset();
    // flush while waiting for the response
    if_req = 1; if_addr = 32'h8000_0200; mem_ready = 1;
    #2;
    n_checks++; if (if_ready !== 1'b1) begin n_fails++; $display("FAIL flush_a_ready got %0b want 1", if_ready); end
    tick(); if_req = 0;
    tick(); flush = 1;
    #2;
    n_checks++; if (if_rvalid !== 1'b0) begin n_fails++; $display("FAIL flush_a_early got %0b want 0", if_rvalid); end
    tick(); flush = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    n_checks++; if (if_rvalid !== 1'b0 || busy !== 1'b1) begin n_fails++; $display("FAIL flush_a_drop got rvalid=%0b busy=%0b want 0/1", if_rvalid, busy); end
    tick(); mem_rvalid = 0; if_req = 1; if_addr = 32'h8000_0204;
    #2;
    n_checks++; if (if_ready !== 1'b1) begin n_fails++; $display("FAIL flush_next_ready got %0b want 1", if_ready); end
    tick(); if_req = 0;
    #2;
    n_checks++; if (mem_addr !== 32'h8000_0204) begin n_fails++; $display("FAIL flush_next_addr got %h want 80000204", mem_addr); end
    tick(); mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #2;
    n_checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h0000_0013) begin n_fails++; $display("FAIL flush_next_rvalid got v=%0b d=%h want 1/00000013", if_rvalid, if_rdata); end
    // flush in the same cycle as the response
    tick(); mem_rvalid = 0; if_req = 1; if_addr = 32'h8000_0300;
    #2;
    n_checks++; if (if_ready !== 1'b1) begin n_fails++; $display("FAIL flush_b_ready got %0b want 1", if_ready); end
    tick(); if_req = 0;
    tick(); flush = 1; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    #2;
    n_checks++; if (if_rvalid !== 1'b0) begin n_fails++; $display("FAIL flush_b_same got %0b want 0", if_rvalid); end
    tick(); flush = 0; mem_rvalid = 0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL flush_b_idle got %0b want 0", busy); end
    clear_inputs();
    $display("test_flush done");
  endtask

  task automatic test_store_stall();
    int req_cycles;
    do_reset();
    ls_req = 1; ls_wen = 1; ls_addr = 32'h8000_1000; ls_wdata = 32'h1234_5678; ls_wmask = 4'hF;
    #2;
    n_checks++; if (ls_ready !== 1'b1) begin n_fails++; $display("FAIL store_ready got %0b want 1", ls_ready); end
    tick();
    // scramble the request inputs to show the fields are held internally
    ls_req = 0; ls_wen = 0; ls_addr = 32'h0; ls_wdata = 32'hFFFF_FFFF; ls_wmask = 4'h0;
    req_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      mem_ready = (c == 5);
      #2;
      if (mem_req === 1'b1) req_cycles++;
      n_checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h8000_1000 || mem_wdata !== 32'h1234_5678 || mem_wmask !== 4'hF) begin n_fails++; $display("FAIL store_fields[%0d] got wen=%0b addr=%h wdata=%h wmask=%h", c, mem_wen, mem_addr, mem_wdata, mem_wmask); end
      tick();
    end
    mem_ready = 0;
    #2;
    n_checks++; if (req_cycles !== 6 || mem_req !== 1'b0) begin n_fails++; $display("FAIL store_req_len got %0d cycles, req now %0b want 6/0", req_cycles, mem_req); end
    mem_rvalid = 1;
    #1;
    n_checks++; if (ls_rvalid !== 1'b1) begin n_fails++; $display("FAIL store_rvalid got %0b want 1", ls_rvalid); end
    tick(); mem_rvalid = 0;
    #2;
    n_checks++; if (ls_rvalid !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL store_done got rvalid=%0b busy=%0b want 0/0", ls_rvalid, busy); end
    clear_inputs();
    $display("test_store_stall done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    ls_req = 1; ls_wen = 0; ls_addr = 32'h8000_3000; mem_ready = 1;
    tick(); ls_req = 0;
    tick(); mem_ready = 0;
    #2;
    n_checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin n_fails++; $display("FAIL rstmid_wait got busy=%0b req=%0b want 1/0", busy, mem_req); end
    rst = 1;
    #1;
    n_checks++; if (busy !== 1'b0 || mem_addr !== 32'h0 || ls_rvalid !== 1'b0) begin n_fails++; $display("FAIL rstmid_async got busy=%0b addr=%h rvalid=%0b want 0/0/0", busy, mem_addr, ls_rvalid); end
    tick(); rst = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    #2;
    n_checks++; if (ls_rvalid !== 1'b0 || if_rvalid !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL rstmid_stale got ls=%0b if=%0b busy=%0b want 0/0/0", ls_rvalid, if_rvalid, busy); end
    clear_inputs();
    $display("test_reset_mid done");
  endtask

  task automatic test_if_flush_idle();
    do_reset();
    if_req = 1; if_addr = 32'h8000_0400; flush = 1;
    #2;
    n_checks++; if (if_ready !== 1'b0 || busy !== 1'b0) begin n_fails++; $display("FAIL idleflush_block got ready=%0b busy=%0b want 0/0", if_ready, busy); end
    tick(); flush = 0;
    #2;
    n_checks++; if (if_ready !== 1'b1) begin n_fails++; $display("FAIL idleflush_grant got %0b want 1", if_ready); end
    tick(); if_req = 0;
    #2;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0400) begin n_fails++; $display("FAIL idleflush_req got req=%0b addr=%h want 1/80000400", mem_req, mem_addr); end
    clear_inputs();
    $display("test_if_flush_idle done");
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_if_basic();
    test_priority();
    test_flush();
    test_store_stall();
    test_reset_mid();
    test_if_flush_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22040750_mem_arbiter.md
# ysyx_22040750_mem_arbiter

Single-port memory arbiter between the instruction-fetch requester (IF stage, feeding the IF/ID register) and the load/store requester (MEM stage). It serializes both onto one memory port, one outstanding transaction at a time. Load/store has priority, with a starvation guard for fetch. A flush input discards an in-flight fetch response on a jump, so a fetch for a squashed path never reaches IF/ID.

## Interface
- MAX_LS_STREAK, 4: consecutive LS grants allowed while IF is waiting before IF is forced; range 1..15.
- I_sys_clk  in  1  clock, rising edge.
- I_rst  in  1  asynchronous, active-high reset.
- I_if_req  in  1  fetch request; held with I_if_addr until O_if_ready.
- I_if_addr  in  32  fetch address.
- O_if_ready  out  1  fetch request accepted this cycle.
- O_if_rvalid  out  1  fetch data valid, one-cycle pulse.
- O_if_rdata  out  32  fetch data.
- I_ls_req  in  1  load/store request; fields held until O_ls_ready.
- I_ls_wen  in  1  1 = store, 0 = load.
- I_ls_addr  in  32  data address.
- I_ls_wdata  in  32  store data.
- I_ls_wmask  in  4  store byte mask.
- O_ls_ready  out  1  load/store request accepted this cycle.
- O_ls_rvalid  out  1  load data valid, or store complete; one-cycle pulse.
- O_ls_rdata  out  32  load data; don't-care for stores.
- I_flush  in  1  cancel the current or pending fetch (jump/redirect).
- O_mem_req  out  1  memory request valid.
- O_mem_wen, O_mem_addr[31:0], O_mem_wdata[31:0], O_mem_wmask[3:0]  out  latched request fields.
- I_mem_ready  in  1  memory accepts O_mem_req this cycle.
- I_mem_rvalid  in  1  memory response valid.
- I_mem_rdata  in  32  memory response data.
- O_busy  out  1  state != IDLE.

## Operation
- FSM states:
  - IDLE.
  - REQ_IF, REQ_LS: O_mem_req=1.
  - WAIT_IF, WAIT_LS: awaiting I_mem_rvalid.
- IDLE grant rules:
  - LS wins if I_ls_req=1 and streak < MAX_LS_STREAK.
  - Otherwise IF wins if I_if_req=1 and I_flush=0.
  - If IF is blocked only by I_flush, LS may be granted regardless of streak.
- On a grant:
  - O_x_ready=1 combinationally in that IDLE cycle.
  - Request fields are latched into the O_mem_* registers.
  - Next state is REQ_x.
  - IF latches wen=0, wmask=0, wdata=0.
- Streak counter:
  - +1 (saturating) on each LS grant while I_if_req=1.
  - Clears on an IF grant.
  - Unchanged on an LS grant while I_if_req=0.
- REQ_x: when I_mem_ready=1, go to WAIT_x. Fields stay stable until then.
- WAIT_x: on I_mem_rvalid=1:
  - Pulse O_x_rvalid with O_x_rdata = I_mem_rdata (combinational pass-through).
  - Next state is IDLE.
- Flush:
  - A drop flag sets on I_flush=1 in REQ_IF or WAIT_IF.
  - O_if_rvalid = WAIT_IF & I_mem_rvalid & ~drop & ~I_flush.
  - The memory transaction still completes and is not aborted; drop clears on entering IDLE.
  - I_flush has no effect on LS transactions.
- I_mem_rvalid outside WAIT_x is ignored. I_mem_ready outside REQ_x is ignored.

## Timing
- Reset (async):
  - State IDLE, streak 0, drop 0, all O_mem_* 0.
  - O_*_ready, O_*_rvalid, O_busy = 0; O_*_rdata follows I_mem_rdata but is qualified by rvalid.
- Reset mid-transaction abandons it. A stale I_mem_rvalid after reset is ignored because the state is IDLE.
- Minimum latency:
  - Accept at T, O_mem_req at T+1 (accepted if I_mem_ready), rvalid at T+2, IDLE at T+3.
  - The next accept is at T+3 at the earliest: one transaction per 3 cycles minimum.
- O_mem_req asserts only in REQ_x. Memory stalls (I_mem_ready=0) extend REQ_x indefinitely.
- O_if_ready and O_ls_ready are never high in the same cycle.
- O_if_ready and O_ls_ready are high only in IDLE.

## Test plan
- IF only, addr 0x80000000, memory ready immediately, rdata 0x00000013 -> O_if_ready at T, O_mem_req at T+1, O_if_rvalid with 0x00000013 at T+2, O_busy back to 0 at T+3.
- Both requesting continuously, MAX_LS_STREAK=4 -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; O_mem_wen/addr match each granted requester.
- IF accepted, I_flush pulsed in WAIT_IF before rvalid (rdata 0xDEADBEEF) -> no O_if_rvalid, next IF grant proceeds normally; repeat with flush in the same cycle as I_mem_rvalid -> also suppressed.
- Store: wen=1, addr 0x80001000, wdata 0x12345678, wmask 0xF, I_mem_ready held low 5 cycles -> O_mem_req high 6 cycles with fields stable, O_ls_rvalid one cycle after acceptance response.
- I_rst asserted asynchronously mid-WAIT_LS, then a late I_mem_rvalid -> all outputs 0 immediately, no O_ls_rvalid, state IDLE.
- I_if_req with I_flush=1 in IDLE and no LS -> O_if_ready=0; next cycle flush low -> IF granted.
